// File: rtl/seq_control.sv
`default_nettype none

// ============================================================================
//  Module      : seq_control (with package seq_control_pkg)
//  Description : Instruction sequencer for a simple accumulator CPU. It walks
//                an 8-state fetch/execute loop, can stall memory reads on
//                mem_ack with a timeout, supports single-step and halt, and
//                counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================

package seq_control_pkg;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

module seq_control
    import seq_control_pkg::*;
#(
    parameter int WAIT_EN  = 1,
    parameter int MAX_WAIT = 8,
    parameter int ICNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  opcode_t           opcode,
    input  logic              zero,
    input  logic              mem_ack,
    input  logic              step_mode,
    input  logic              resume,
    output logic              load_ac,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              inc_pc,
    output logic              load_pc,
    output logic              load_ir,
    output logic              halt,
    output logic              err,
    output logic [ICNT_W-1:0] icount
);

    localparam logic [3:0] S_INST_ADDR  = 4'd0;
    localparam logic [3:0] S_INST_FETCH = 4'd1;
    localparam logic [3:0] S_INST_LOAD  = 4'd2;
    localparam logic [3:0] S_IDLE       = 4'd3;
    localparam logic [3:0] S_OP_ADDR    = 4'd4;
    localparam logic [3:0] S_OP_FETCH   = 4'd5;
    localparam logic [3:0] S_ALU_OP     = 4'd6;
    localparam logic [3:0] S_STORE      = 4'd7;
    localparam logic [3:0] S_HALTED     = 4'd8;

    // Wait counter never exceeds MAX_WAIT-1 (<= 254), so 8 bits suffice.
    localparam logic [7:0]        WAIT_LAST = 8'(MAX_WAIT - 1);
    localparam logic [ICNT_W-1:0] ICNT_ONE  = ICNT_W'(1);

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [7:0] r_wait_cnt;
    logic       w_aluop;
    logic       w_stall_state;
    logic       w_held;
    logic       w_timeout;

    assign w_aluop = (opcode == ADD) || (opcode == AND) ||
                     (opcode == XOR) || (opcode == LDA);

    // Only instruction fetch and an ALU operand fetch wait on memory.
    assign w_stall_state = (WAIT_EN != 0) &&
                           ((r_state == S_INST_FETCH) ||
                            ((r_state == S_OP_FETCH) && w_aluop));
    assign w_held    = w_stall_state && !mem_ack;
    assign w_timeout = w_held && (r_wait_cnt == WAIT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_INST_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INST_ADDR:  w_next = S_INST_FETCH;
            S_INST_FETCH: begin
                if (w_timeout) begin
                    w_next = S_HALTED;
                end else if (!w_held) begin
                    w_next = S_INST_LOAD;
                end
            end
            S_INST_LOAD:  w_next = S_IDLE;
            S_IDLE:       w_next = S_OP_ADDR;
            S_OP_ADDR:    w_next = (opcode == HLT) ? S_HALTED : S_OP_FETCH;
            S_OP_FETCH: begin
                if (w_timeout) begin
                    w_next = S_HALTED;
                end else if (!w_held) begin
                    w_next = S_ALU_OP;
                end
            end
            S_ALU_OP:     w_next = S_STORE;
            S_STORE:      w_next = step_mode ? S_HALTED : S_INST_ADDR;
            S_HALTED: begin
                // A memory timeout can only be cleared by reset.
                if (resume && !err) begin
                    w_next = S_INST_ADDR;
                end
            end
            default:      w_next = S_INST_ADDR;
        endcase
    end

    // Control output decode from current state plus opcode/zero qualifiers.
    always_comb begin
        load_ac = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        case (r_state)
            S_INST_FETCH: begin
                mem_rd = 1'b1;
            end
            S_INST_LOAD, S_IDLE: begin
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            S_OP_ADDR: begin
                inc_pc = 1'b1;
                halt   = (opcode == HLT);
            end
            S_OP_FETCH: begin
                mem_rd = w_aluop;
            end
            S_ALU_OP: begin
                load_ac = w_aluop;
                mem_rd  = w_aluop;
                inc_pc  = (opcode == SKZ) && zero;
                load_pc = (opcode == JMP);
            end
            S_STORE: begin
                load_ac = w_aluop;
                mem_rd  = w_aluop;
                mem_wr  = (opcode == STO);
                inc_pc  = (opcode == JMP);
                load_pc = (opcode == JMP);
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Stall counter: counts held cycles, restarts on any state change.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wait_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_wait_cnt <= 8'd0;
        end else if (w_held) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            err <= 1'b0;
        end else if (w_timeout) begin
            err <= 1'b1;
        end
    end

    // Retired-instruction counter: one count per STORE exit, free wrap.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            icount <= '0;
        end else if (r_state == S_STORE) begin
            icount <= icount + ICNT_ONE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_control.sv
`default_nettype none

// ============================================================================
//  Module      : tb_seq_control
//  Description : Directed, table-driven bench for seq_control. A second
//                instance with a 2-bit retire counter shares all inputs so
//                the counter wrap can be observed alongside the main run.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_seq_control;
    import seq_control_pkg::*;

    localparam logic [6:0] O_LA = 7'h40;
    localparam logic [6:0] O_MR = 7'h20;
    localparam logic [6:0] O_MW = 7'h10;
    localparam logic [6:0] O_IP = 7'h08;
    localparam logic [6:0] O_LP = 7'h04;
    localparam logic [6:0] O_LI = 7'h02;
    localparam logic [6:0] O_HT = 7'h01;
    localparam logic [6:0] O_NO = 7'h00;

    typedef struct {
        logic       rst;
        opcode_t    op;
        logic       zero;
        logic       ack;
        logic       stp;
        logic       res;
        logic [6:0] outs;
        logic       err;
        int         icnt;
    } vec_t;

    logic    clk;
    logic    rst_;
    opcode_t opcode;
    logic    zero;
    logic    mem_ack;
    logic    step_mode;
    logic    resume;

    logic        load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt, err;
    logic [15:0] icount;
    logic        load_ac2, mem_rd2, mem_wr2, inc_pc2, load_pc2, load_ir2, halt2, err2;
    logic [1:0]  icount2;

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    seq_control #(.WAIT_EN(1), .MAX_WAIT(8), .ICNT_W(16)) dut (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .step_mode(step_mode), .resume(resume),
        .load_ac(load_ac), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_ir(load_ir),
        .halt(halt), .err(err), .icount(icount)
    );

    seq_control #(.WAIT_EN(1), .MAX_WAIT(8), .ICNT_W(2)) dut_w2 (
        .clk(clk), .rst_(rst_), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .step_mode(step_mode), .resume(resume),
        .load_ac(load_ac2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
        .inc_pc(inc_pc2), .load_pc(load_pc2), .load_ir(load_ir2),
        .halt(halt2), .err(err2), .icount(icount2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input opcode_t o, input logic z,
                                input logic a, input logic s, input logic rs,
                                input logic [6:0] ou, input logic e, input int ic);
        vec_t v;
        v.rst = r; v.op = o; v.zero = z; v.ack = a; v.stp = s; v.res = rs;
        v.outs = ou; v.err = e; v.icnt = ic;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then clock.
    task automatic apply(input vec_t v, input int idx);
        logic [15:0] ic16;
        logic [1:0]  ic2;
        logic [31:0] ic_full;
        ic_full = v.icnt;
        ic16 = ic_full[15:0];
        ic2  = ic_full[1:0];
        rst_ = v.rst; opcode = v.op; zero = v.zero; mem_ack = v.ack;
        step_mode = v.stp; resume = v.res;
        @(negedge clk);
        chk("ctrl", idx, {25'd0, load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt},
            {25'd0, v.outs});
        chk("err", idx, {31'd0, err}, {31'd0, v.err});
        chk("icount", idx, {16'd0, icount}, {16'd0, ic16});
        chk("icount_w2", idx, {30'd0, icount2}, {30'd0, ic2});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_ = 1'b0; opcode = ADD; zero = 1'b0; mem_ack = 1'b1;
        step_mode = 1'b0; resume = 1'b0;

        // Reset, then one ADD instruction with memory always ready.
        vq.push_back(mk(0, ADD, 0, 1, 0, 0, O_NO,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_NO,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR|O_LI,   0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR|O_LI,   0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_IP,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_LA|O_MR,   0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_LA|O_MR,   0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_NO,        0, 1));
        // Three stalled fetch cycles, then SKZ with zero set.
        vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_MR,        0, 1));
        vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_MR,        0, 1));
        vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_MR,        0, 1));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR,        0, 1));
        vq.push_back(mk(1, SKZ, 1, 1, 0, 0, O_MR|O_LI,   0, 1));
        vq.push_back(mk(1, SKZ, 1, 1, 0, 0, O_MR|O_LI,   0, 1));
        vq.push_back(mk(1, SKZ, 1, 1, 0, 0, O_IP,        0, 1));
        vq.push_back(mk(1, SKZ, 1, 0, 0, 0, O_NO,        0, 1));
        vq.push_back(mk(1, SKZ, 1, 1, 0, 0, O_IP,        0, 1));
        vq.push_back(mk(1, SKZ, 1, 1, 0, 0, O_NO,        0, 1));
        // STO: write strobe in STORE only; resume outside HALTED ignored.
        vq.push_back(mk(1, STO, 1, 1, 0, 1, O_NO,        0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_MR,        0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_MR|O_LI,   0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_MR|O_LI,   0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_IP,        0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_NO,        0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_NO,        0, 2));
        vq.push_back(mk(1, STO, 1, 1, 0, 0, O_MW,        0, 2));
        // JMP in step mode: halts after STORE, fourth retire wraps 2-bit count.
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_NO,        0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_MR,        0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_MR|O_LI,   0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_MR|O_LI,   0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_IP,        0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_NO,        0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_LP,        0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 1, 0, O_IP|O_LP,   0, 3));
        vq.push_back(mk(1, JMP, 0, 1, 0, 0, O_HT,        0, 4));
        vq.push_back(mk(1, JMP, 0, 1, 0, 1, O_HT,        0, 4));
        vq.push_back(mk(1, HLT, 0, 1, 0, 0, O_NO,        0, 4));
        // HLT: halt in OP_ADDR, HALTED, resume restarts, count unchanged.
        vq.push_back(mk(1, HLT, 0, 1, 0, 0, O_MR,        0, 4));
        vq.push_back(mk(1, HLT, 0, 1, 0, 0, O_MR|O_LI,   0, 4));
        vq.push_back(mk(1, HLT, 0, 1, 0, 0, O_MR|O_LI,   0, 4));
        vq.push_back(mk(1, HLT, 0, 1, 0, 0, O_IP|O_HT,   0, 4));
        vq.push_back(mk(1, HLT, 0, 1, 0, 0, O_HT,        0, 4));
        vq.push_back(mk(1, HLT, 0, 1, 0, 1, O_HT,        0, 4));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_NO,        0, 4));
        // Reset pulsed while stalled in OP_FETCH.
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR,        0, 4));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR|O_LI,   0, 4));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR|O_LI,   0, 4));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_IP,        0, 4));
        vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_MR,        0, 4));
        vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_MR,        0, 4));
        vq.push_back(mk(0, ADD, 0, 0, 0, 0, O_NO,        0, 0));
        vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_NO,        0, 0));
        // Fetch timeout: 8 held cycles, then sticky err blocks resume.
        for (int i = 0; i < 8; i++) begin
            vq.push_back(mk(1, ADD, 0, 0, 0, 0, O_MR,    0, 0));
        end
        vq.push_back(mk(1, ADD, 0, 0, 0, 1, O_HT,        1, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 1, O_HT,        1, 0));
        vq.push_back(mk(0, ADD, 0, 1, 0, 0, O_NO,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_NO,        0, 0));
        vq.push_back(mk(1, ADD, 0, 1, 0, 0, O_MR,        0, 0));

        foreach (vq[i]) begin
            apply(vq[i], i);
        end

        // Operand fetch held for MAX_WAIT-1 cycles must not time out.
        apply(mk(1, ADD, 0, 1, 0, 0, O_MR|O_LI, 0, 0), 100);
        apply(mk(1, ADD, 0, 1, 0, 0, O_MR|O_LI, 0, 0), 101);
        apply(mk(1, ADD, 0, 1, 0, 0, O_IP,      0, 0), 102);
        for (int i = 0; i < 7; i++) begin
            apply(mk(1, ADD, 0, 0, 0, 0, O_MR,  0, 0), 103 + i);
        end
        apply(mk(1, ADD, 0, 1, 0, 0, O_MR,      0, 0), 110);
        apply(mk(1, ADD, 0, 1, 0, 0, O_LA|O_MR, 0, 0), 111);
        apply(mk(1, ADD, 0, 1, 0, 0, O_LA|O_MR, 0, 0), 112);
        apply(mk(1, ADD, 0, 1, 0, 0, O_NO,      0, 1), 113);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- WAIT_EN  1  1 = memory reads stall on mem_ack; 0 = mem_ack ignored, fixed 8-state sequence.
- MAX_WAIT  8  stall cycles tolerated before timeout; legal range 1..255.
- ICNT_W  16  width of the retired-instruction counter; minimum 1.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst_  in  1  asynchronous, active-low reset.
- opcode  in  opcode_t  current instruction opcode (HLT,SKZ,ADD,AND,XOR,LDA,STO,JMP) from package typedefs.
- zero  in  1  accumulator-zero flag.
- mem_ack  in  1  memory read data valid.
- step_mode  in  1  1 = pause after every instruction.
- resume  in  1  leave HALTED.
- load_ac, mem_rd, mem_wr, inc_pc, load_pc, load_ir, halt  out  1 each  datapath controls.
- err  out  1  sticky memory-timeout flag.
- icount  out  ICNT_W  retired-instruction count.
REQ-003 One clock and asynchronous active-low reset: clk, rst_; state, wait counter, err and icount change only on posedge clk or negedge rst_.

Function
REQ-004 States: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED; control outputs decoded combinationally from state and inputs (Moore plus opcode/zero qualifiers).
REQ-005 Base sequence, one state per cycle: INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR.
REQ-006 ALUOP means opcode in {ADD,AND,XOR,LDA}. Outputs not listed are 0.
- INST_ADDR: all 0.
- INST_FETCH: mem_rd.
- INST_LOAD, IDLE: mem_rd, load_ir.
- OP_ADDR: inc_pc; halt = (opcode==HLT).
- OP_FETCH: mem_rd = ALUOP.
- ALU_OP: load_ac = mem_rd = ALUOP; inc_pc = (SKZ & zero); load_pc = JMP.
- STORE: load_ac = mem_rd = ALUOP; mem_wr = STO; inc_pc = load_pc = JMP.
- HALTED: halt only.
REQ-007 OP_ADDR with opcode==HLT: next state HALTED, not OP_FETCH.
REQ-008 WAIT_EN=1: INST_FETCH, and OP_FETCH when ALUOP, hold while mem_ack=0; advance on the cycle mem_ack=1. mem_ack in any other state is ignored.
REQ-009 Wait counter: increments each held cycle; clears on every state change. Timeout = held cycle with counter==MAX_WAIT-1 and mem_ack=0: next state HALTED, err set.
REQ-010 err sticky; cleared only by reset.
REQ-011 HALTED->INST_ADDR when resume=1 and err=0; otherwise HALTED holds. resume outside HALTED is ignored.
REQ-012 STORE: next state HALTED if step_mode=1, else INST_ADDR. step_mode is sampled only in STORE.
REQ-013 icount increments by 1 on every STORE exit and wraps from all-ones to 0; HLT and timeout do not increment it.

Reset
REQ-014 rst_=0 at any time, including mid-stall or in HALTED: state=INST_ADDR, wait counter=0, err=0, icount=0; all control outputs 0 while in reset.
REQ-015 First active clock after rst_ deasserts: INST_ADDR->INST_FETCH.

Verification
REQ-016 WAIT_EN=1, mem_ack=1, opcode=ADD -> 8-cycle loop; load_ac=1 in ALU_OP and STORE; icount=1 after first STORE.
REQ-017 mem_ack low 3 cycles in INST_FETCH (MAX_WAIT=8) -> INST_FETCH held 4 cycles, mem_rd=1 throughout, err=0.
REQ-018 mem_ack held 0 in INST_FETCH, MAX_WAIT=8 -> HALTED after 8 held cycles; err=1, halt=1; resume=1 -> remains HALTED.
REQ-019 opcode=HLT -> halt=1 in OP_ADDR, then HALTED; resume=1 -> INST_ADDR next cycle; icount unchanged.
REQ-020 step_mode=1, opcode=JMP -> load_pc=1 in ALU_OP; HALTED after STORE; icount increments; resume continues. ICNT_W=2: fourth retire -> icount=0.
REQ-021 rst_ pulsed low mid-stall in OP_FETCH -> immediate INST_ADDR, all outputs 0, icount=0.
